// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, init ROM, cycle defaults and helpers for the HD44780 writer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PWRUP = 3'd5
    } lcd_state_e;

    // Cycle counts for a 50 MHz clock
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_PULSE_CYC  = 12;
    localparam int DEF_HOLD_CYC   = 2;
    localparam int DEF_SHORT_CYC  = 2000;
    localparam int DEF_LONG_CYC   = 82000;
    localparam int DEF_PWRUP_CYC  = 2000000;
    localparam int DEF_FIFO_DEPTH = 4;

    // Function set 8-bit/2-line, display on, clear, entry mode increment
    localparam int INIT_LEN = 4;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear display and return home need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

    function automatic int cyc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered full/empty flags
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push  = push && !full_q;
    assign do_pop   = pop && !empty_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

    // Next pointers, occupancy and flags; flags come from the next count so they are registered
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; stale entries are never read while empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lcd_writer.sv
// rtl/lcd_writer.sv - HD44780 byte writer with command FIFO and bus timing; LCD_INIT_EN adds power-up delay and init ROM
module lcd_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int SHORT_CYC  = DEF_SHORT_CYC,
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int PWRUP_CYC  = DEF_PWRUP_CYC,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_vld,
    output logic       wr_rdy,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       busy,
    input  logic       lcd_on,
    output logic       lcd_pwr,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int MAX_CYC = cyc_max(cyc_max(cyc_max(SETUP_CYC, PULSE_CYC), cyc_max(HOLD_CYC, SHORT_CYC)),
                                     cyc_max(LONG_CYC, PWRUP_CYC));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
`endif

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d, en_q, en_d, pwr_q, pwr_d, live_q, live_d;
    logic [7:0]       data_q, data_d;
`ifdef LCD_INIT_EN
    logic [2:0]       init_idx_q, init_idx_d;
`endif

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [8:0] fifo_dout;
    logic       src_vld, src_rom, init_pending;
    logic [8:0] src_word;

    // live_q keeps handshake and busy low through reset and the cycle after it
    assign wr_rdy    = live_q && !fifo_full;
    assign fifo_push = wr_vld && wr_rdy;
    assign busy      = live_q && (!fifo_empty || (state_q != ST_IDLE) || init_pending);
    assign lcd_pwr   = pwr_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_data  = data_q;

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({wr_rs, wr_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next byte source: init ROM entries take priority over core bytes until the ROM is exhausted
    always_comb begin
        src_vld      = !fifo_empty;
        src_word     = fifo_dout;
        src_rom      = 1'b0;
        init_pending = 1'b0;
`ifdef LCD_INIT_EN
        init_pending = (state_q == ST_PWRUP) || (init_idx_q < 3'(INIT_LEN));
        if (init_idx_q < 3'(INIT_LEN)) begin
            src_vld  = 1'b1;
            src_rom  = 1'b1;
            src_word = {1'b0, INIT_ROM[init_idx_q[1:0]]};
        end
`endif
    end

    // Write-cycle sequencer sharing one down-counter across every timed state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        data_d   = data_q;
        en_d     = en_q;
        pwr_d    = lcd_on;
        live_d   = 1'b1;
        fifo_pop = 1'b0;
`ifdef LCD_INIT_EN
        init_idx_d = init_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                if (src_vld) begin
                    rs_d     = src_word[8];
                    data_d   = src_word[7:0];
                    fifo_pop = !src_rom;
`ifdef LCD_INIT_EN
                    if (src_rom) init_idx_d = init_idx_q + 1'b1;
`endif
                    state_d  = ST_SETUP;
                    cnt_d    = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? LONG_LD : SHORT_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT, ST_PWRUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers; reset drops EN immediately and discards the byte in flight
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_EN
            state_q    <= ST_PWRUP;
            cnt_q      <= PWRUP_LD;
            init_idx_q <= '0;
`else
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
`endif
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            en_q   <= 1'b0;
            pwr_q  <= 1'b0;
            live_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            pwr_q   <= pwr_d;
            live_q  <= live_d;
`ifdef LCD_INIT_EN
            init_idx_q <= init_idx_d;
`endif
        end
    end

endmodule
